mc14500_sequencer: RTL and testbench
====================================

// Module: mc14500_sequencer
// PURPOSE
//  Program sequencer for the ICU. Owns the program counter (PC) and fetches words from async-read program memory.
//  Splits each word into opcode (to ICU) and operand (I/O address / jump target).
//  Acts on ICU jmp/rtn/flag_f: JMP = call (push return addr), RTN = pop, NOPF = halt until run.
//  Sits between program ROM, ICU and the I/O address decoder.
// PARAMETERS
//  ADDR_W       8  width of PC, program address and operand field
//  STACK_DEPTH  4  return-stack entries (>=1)
// PORTS
//  clk              in   1           system clock; PC/stack/state update on posedge
//  rst_n            in   1           asynchronous, active-low reset
//  run              in   1           one-cycle pulse: leave HALT
//  prog_addr        out  ADDR_W      program memory address (= PC)
//  prog_data        in   4+ADDR_W    [ADDR_W+3:ADDR_W] opcode, [ADDR_W-1:0] operand; valid same cycle
//  icu_instruction  out  4           instruction_t to ICU
//  icu_rst          out  1           active-high reset to ICU
//  icu_jmp          in   1           ICU jmp
//  icu_rtn          in   1           ICU rtn
//  icu_flag_f       in   1           ICU flag_f
//  io_addr          out  ADDR_W      operand of current word, to I/O decode
//  halted           out  1           1 while in HALT
//  stack_err        out  1           sticky: overflow or underflow since reset
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - PC=0, stack empty, stack_err=0, state=INIT.
//   - icu_rst=1, halted=0, icu_instruction=NOPO.
//  States: INIT -> RUN (first posedge after rst_n=1); RUN -> HALT; HALT -> RUN.
//  INIT
//   - icu_rst=1 for exactly one clk after reset release.
//   - PC held at 0. Next: RUN.
//  RUN
//   - icu_rst=0; icu_instruction = prog_data opcode; io_addr = prog_data operand.
//   - ICU latches the opcode on negedge and executes on the following posedge.
//   - icu_jmp/icu_rtn/icu_flag_f sampled at the posedge ending the cycle refer to the word fetched in that cycle.
//   - Exactly one PC update per posedge, priority:
//     - icu_jmp:
//       - PC <= operand.
//       - Push PC+1 (mod 2^ADDR_W).
//       - If the stack is full: push dropped, stack_err<=1, jump still taken.
//     - icu_rtn:
//       - PC <= popped value.
//       - If the stack is empty: PC <= 0, stack_err<=1.
//       - The ICU skips the instruction at the return address, so every call is followed by a one-word slot (program convention).
//     - icu_flag_f: PC <= PC+1, state <= HALT.
//     - otherwise: PC <= PC+1.
//   - Skipped instructions: ICU does not assert jmp/flag_f, so the sequencer just increments.
//   - PC wraps 2^ADDR_W-1 -> 0 without error.
//  HALT
//   - icu_instruction forced to NOPO; PC, prog_addr and stack held.
//   - halted=1; icu_rtn/icu_jmp ignored.
//   - run=1 at posedge -> RUN (fetch resumes at held PC next cycle).
//  run in INIT or RUN is ignored.
//  rst_n asserted mid-operation (any state, incl. mid-call) clears all state immediately; no pending push/pop survives.
//  Outputs are registered state or combinational from state + prog_data; no combinational path from icu_* inputs to outputs.
// STRUCTURE
//  Shared `instructions` package:
//   - Existing instruction_t / NOPO..NOPF used unchanged.
//   - Add seq_state_t {SEQ_INIT, SEQ_RUN, SEQ_HALT}.
//   - Add OPCODE_W=4.
//  Sub-module mc14500_return_stack #(ADDR_W, STACK_DEPTH):
//   - LIFO with push/pop/data_in/data_out/full/empty.
//   - Registered pointer, async-read top-of-stack.
//   - Simultaneous push+pop is impossible by construction.
//   - Sub-module asserts if push+pop are ever simultaneous.
// TESTING
//  1 Reset release, ROM of LD/AND/STO at 0..2 -> icu_rst high 1 cycle; prog_addr 0,1,2,3 on successive cycles; io_addr tracks operands.
//  2 JMP 0x40 at 0x10, slot at 0x11, RTN at 0x42 -> PC 0x10,0x40,0x41,0x42,0x11,0x12; ICU skips 0x11; stack empty after.
//  3 Nested 5 calls with STACK_DEPTH=4 -> 5th jump taken, stack_err=1; RTN on empty stack -> PC=0, stack_err stays 1.
//  4 NOPF at 0x20 -> halted=1 from next cycle, prog_addr held 0x21, icu_instruction=NOPO for 10 cycles; run pulse -> fetch 0x21.
//  5 SKZ with RR=0 before JMP at 0xFE -> no jump, PC 0xFE->0xFF->0x00 (wrap), stack unchanged.
//  6 rst_n low for 1 cycle mid-call (depth 2) -> PC=0, stack empty, stack_err=0, icu_rst=1 through INIT cycle.

Source files
------------

// File: rtl/mc14500_sequencer_pkg.sv
// Shared MC14500 definitions: ICU instruction encoding and sequencer state type.
package mc14500_sequencer_pkg;

   localparam int unsigned OPCODE_W = 4;

   typedef enum logic [OPCODE_W-1:0] {
      NOPO = 4'h0,
      LD   = 4'h1,
      LDC  = 4'h2,
      AND  = 4'h3,
      ANDC = 4'h4,
      OR   = 4'h5,
      ORC  = 4'h6,
      XNOR = 4'h7,
      STO  = 4'h8,
      STOC = 4'h9,
      IEN  = 4'hA,
      OEN  = 4'hB,
      JMP  = 4'hC,
      RTN  = 4'hD,
      SKZ  = 4'hE,
      NOPF = 4'hF
   } instruction_t;

   typedef enum logic [1:0] {
      SEQ_INIT,
      SEQ_RUN,
      SEQ_HALT
   } seq_state_t;

endpackage

// File: rtl/mc14500_return_stack.sv
// Return-address LIFO for the MC14500 sequencer: registered depth counter,
// asynchronous read of the top entry.
module mc14500_return_stack #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] data_in,
   output logic [ADDR_W-1:0] data_out,
   output logic              full,
   output logic              empty
);

   localparam int unsigned CntW = $clog2(STACK_DEPTH + 1);
   localparam int unsigned PtrW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [CntW-1:0]   count_q, count_d;
   logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
   logic [PtrW-1:0]   wr_idx, top_idx;

   always_comb begin
      wr_idx   = PtrW'(count_q);
      top_idx  = PtrW'(count_q - CntW'(1));
      full     = (count_q == CntW'(STACK_DEPTH));
      empty    = (count_q == '0);
      data_out = mem_q[top_idx];
      count_d  = count_q;
      if (push && !full) begin
         count_d = count_q + CntW'(1);
      end else if (pop && !empty) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         for (int i = 0; i < int'(STACK_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         if (push && !full) begin
            mem_q[wr_idx] <= data_in;
         end
      end
   end

   // The sequencer's jmp/rtn priority makes a same-cycle push and pop impossible.
   assert property (@(posedge clk) disable iff (!rst_n) !(push && pop));

endmodule

// File: rtl/mc14500_sequencer.sv
// Program sequencer for the MC14500 ICU: owns the PC, fetches program words,
// and handles call/return/halt requests from the ICU.
module mc14500_sequencer
   import mc14500_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  run,
   output logic [ADDR_W-1:0]     prog_addr,
   input  logic [ADDR_W+3:0]     prog_data,
   output logic [OPCODE_W-1:0]   icu_instruction,
   output logic                  icu_rst,
   input  logic                  icu_jmp,
   input  logic                  icu_rtn,
   input  logic                  icu_flag_f,
   output logic [ADDR_W-1:0]     io_addr,
   output logic                  halted,
   output logic                  stack_err
);

   seq_state_t          state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                err_q, err_d;
   logic [ADDR_W-1:0]   pc_inc;
   logic [ADDR_W-1:0]   operand;
   logic [OPCODE_W-1:0] opcode;
   logic                push, pop;
   logic [ADDR_W-1:0]   stack_top;
   logic                stack_full, stack_empty;

   assign opcode  = prog_data[ADDR_W+3:ADDR_W];
   assign operand = prog_data[ADDR_W-1:0];
   assign pc_inc  = pc_q + ADDR_W'(1);

   mc14500_return_stack #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop),
      .data_in  (pc_inc),
      .data_out (stack_top),
      .full     (stack_full),
      .empty    (stack_empty)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      err_d   = err_q;
      push    = 1'b0;
      pop     = 1'b0;
      case (state_q)
         SEQ_INIT: state_d = SEQ_RUN;
         SEQ_RUN: begin
            if (icu_jmp) begin
               // A call on a full stack still jumps; only the return address is lost.
               pc_d = operand;
               if (stack_full) begin
                  err_d = 1'b1;
               end else begin
                  push = 1'b1;
               end
            end else if (icu_rtn) begin
               if (stack_empty) begin
                  pc_d  = '0;
                  err_d = 1'b1;
               end else begin
                  pc_d = stack_top;
                  pop  = 1'b1;
               end
            end else if (icu_flag_f) begin
               pc_d    = pc_inc;
               state_d = SEQ_HALT;
            end else begin
               pc_d = pc_inc;
            end
         end
         SEQ_HALT: begin
            if (run) begin
               state_d = SEQ_RUN;
            end
         end
         default: state_d = SEQ_INIT;
      endcase
   end

   always_comb begin
      prog_addr       = pc_q;
      io_addr         = operand;
      icu_rst         = (state_q == SEQ_INIT);
      halted          = (state_q == SEQ_HALT);
      stack_err       = err_q;
      icu_instruction = (state_q == SEQ_RUN) ? opcode : NOPO;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SEQ_INIT;
         pc_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_mc14500_sequencer.sv
// Directed, table-driven bench for mc14500_sequencer; the bench plays the ICU
// and a combinational program ROM.
module tb_mc14500_sequencer;
   import mc14500_sequencer_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic [7:0]  prog_addr;
   logic [11:0] prog_data;
   logic [3:0]  icu_instruction;
   logic        icu_rst;
   logic        icu_jmp;
   logic        icu_rtn;
   logic        icu_flag_f;
   logic [7:0]  io_addr;
   logic        halted;
   logic        stack_err;

   logic [11:0] rom [256];

   assign prog_data = rom[prog_addr];

   mc14500_sequencer #(
      .ADDR_W      (8),
      .STACK_DEPTH (4)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .run             (run),
      .prog_addr       (prog_addr),
      .prog_data       (prog_data),
      .icu_instruction (icu_instruction),
      .icu_rst         (icu_rst),
      .icu_jmp         (icu_jmp),
      .icu_rtn         (icu_rtn),
      .icu_flag_f      (icu_flag_f),
      .io_addr         (io_addr),
      .halted          (halted),
      .stack_err       (stack_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef enum {K_RST, K_INIT, K_RUN, K_HALT} kind_e;

   typedef struct {
      logic       rst_n;
      logic       run;
      logic       jmp;
      logic       rtn;
      logic       flag;
      logic [7:0] addr;
      logic [3:0] op;
      logic [7:0] io;
      logic       rst_o;
      logic       halt;
      logic       err;
   } vec_t;

   vec_t       vecs[$];
   int         n_vec;
   int         n_bad;
   logic [7:0] fa;
   logic       fe;

   task automatic add(input kind_e k, input logic [7:0] a, input logic e, input logic rn,
                      input logic r, input logic j, input logic t, input logic f);
      vec_t v;
      v.rst_n = rn;
      v.run   = r;
      v.jmp   = j;
      v.rtn   = t;
      v.flag  = f;
      v.addr  = (k == K_RST || k == K_INIT) ? 8'h00 : a;
      v.io    = rom[v.addr][7:0];
      v.op    = (k == K_RUN) ? rom[v.addr][11:8] : 4'h0;
      v.rst_o = (k == K_RST || k == K_INIT);
      v.halt  = (k == K_HALT);
      v.err   = e;
      vecs.push_back(v);
   endtask

   // Straight-line fetches from fa up to (not including) stop.
   task automatic plain_to(input logic [7:0] stop);
      while (fa != stop) begin
         add(K_RUN, fa, fe, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         fa = fa + 8'h01;
      end
   endtask

   task automatic call(input logic [7:0] tgt);
      add(K_RUN, fa, fe, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      fa = tgt;
   endtask

   task automatic ret(input logic [7:0] dst);
      add(K_RUN, fa, fe, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      fa = dst;
   endtask

   task automatic chk(input string nm, input int idx, input logic [7:0] got,
                      input logic [7:0] want);
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s (step %0d): got %h, expected %h", nm, idx, got, want);
      end
   endtask

   initial begin
      n_vec      = 0;
      n_bad      = 0;
      rst_n      = 1'b0;
      run        = 1'b0;
      icu_jmp    = 1'b0;
      icu_rtn    = 1'b0;
      icu_flag_f = 1'b0;

      for (int a = 0; a < 256; a++) begin
         rom[a] = {LD, 8'(a) ^ 8'hA5};
      end
      rom[8'h01][11:8] = AND;
      rom[8'h02][11:8] = STO;
      rom[8'h0F][11:8] = SKZ;
      rom[8'h10]       = {JMP, 8'h40};
      rom[8'h11][11:8] = NOPO;
      rom[8'h41][11:8] = OR;
      rom[8'h42][11:8] = RTN;
      rom[8'h12]       = {JMP, 8'h50};
      rom[8'h50]       = {JMP, 8'h60};
      rom[8'h60]       = {JMP, 8'h70};
      rom[8'h70]       = {JMP, 8'h80};
      rom[8'h80]       = {JMP, 8'h90};
      rom[8'h90][11:8] = RTN;
      rom[8'h72][11:8] = RTN;
      rom[8'h62][11:8] = RTN;
      rom[8'h52][11:8] = RTN;
      rom[8'h14][11:8] = RTN;
      rom[8'h13][11:8] = NOPO;
      rom[8'h51][11:8] = NOPO;
      rom[8'h61][11:8] = NOPO;
      rom[8'h71][11:8] = NOPO;
      rom[8'h20][11:8] = NOPF;
      rom[8'hFD][11:8] = SKZ;
      rom[8'hFE]       = {JMP, 8'h80};

      fa = 8'h00;
      fe = 1'b0;
      // Reset and INIT, then straight-line LD/AND/STO; a run pulse in RUN is ignored.
      add(K_RST,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(K_INIT, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      plain_to(8'h05);
      add(K_RUN, fa, fe, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      fa = fa + 8'h01;
      // Call 0x40 from 0x10, return lands on the 0x11 slot.
      plain_to(8'h10);
      call(8'h40);
      plain_to(8'h42);
      ret(8'h11);
      plain_to(8'h12);
      // Five nested calls into a four-deep stack; the fifth still jumps.
      call(8'h50);
      call(8'h60);
      call(8'h70);
      call(8'h80);
      call(8'h90);
      fe = 1'b1;
      ret(8'h71);
      plain_to(8'h72);
      ret(8'h61);
      plain_to(8'h62);
      ret(8'h51);
      plain_to(8'h52);
      ret(8'h13);
      plain_to(8'h14);
      ret(8'h00);
      // SKZ at 0x0F skips the JMP at 0x10 this time; NOPF at 0x20 halts.
      plain_to(8'h20);
      add(K_RUN, fa, fe, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      fa = 8'h21;
      for (int i = 0; i < 10; i++) begin
         add(K_HALT, fa, fe, 1'b1, 1'b0, (i == 3), (i == 6), 1'b0);
      end
      add(K_HALT, fa, fe, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      // Resume at 0x21; SKZ at 0xFD skips the JMP at 0xFE; PC wraps to 0.
      plain_to(8'h00);
      plain_to(8'h10);
      call(8'h40);
      plain_to(8'h42);
      ret(8'h11);
      plain_to(8'h12);
      call(8'h50);
      call(8'h60);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst_n      = vecs[i].rst_n;
         run        = vecs[i].run;
         icu_jmp    = vecs[i].jmp;
         icu_rtn    = vecs[i].rtn;
         icu_flag_f = vecs[i].flag;
         #1;
         n_vec++;
         chk("prog_addr", i, prog_addr, vecs[i].addr);
         chk("io_addr", i, io_addr, vecs[i].io);
         chk("icu_instruction", i, 8'(icu_instruction), 8'(vecs[i].op));
         chk("icu_rst", i, 8'(icu_rst), 8'(vecs[i].rst_o));
         chk("halted", i, 8'(halted), 8'(vecs[i].halt));
         chk("stack_err", i, 8'(stack_err), 8'(vecs[i].err));
      end

      // Reset asserted mid-call at stack depth 2 while the ICU requests a jump.
      @(negedge clk);
      icu_jmp = 1'b0;
      #1;
      n_vec++;
      chk("mid_call_pc", 900, prog_addr, 8'h60);
      chk("mid_call_err", 900, 8'(stack_err), 8'h01);
      chk("mid_call_not_empty", 900, 8'(dut.u_stack.empty), 8'h00);
      rst_n   = 1'b0;
      icu_jmp = 1'b1;
      #1;
      n_vec++;
      chk("rst_pc", 901, prog_addr, 8'h00);
      chk("rst_icu_rst", 901, 8'(icu_rst), 8'h01);
      chk("rst_err", 901, 8'(stack_err), 8'h00);
      chk("rst_empty", 901, 8'(dut.u_stack.empty), 8'h01);
      chk("rst_instr", 901, 8'(icu_instruction), 8'(NOPO));
      @(negedge clk);
      rst_n   = 1'b1;
      icu_jmp = 1'b0;
      #1;
      n_vec++;
      chk("init_pc", 902, prog_addr, 8'h00);
      chk("init_icu_rst", 902, 8'(icu_rst), 8'h01);
      chk("init_empty", 902, 8'(dut.u_stack.empty), 8'h01);
      @(negedge clk);
      #1;
      n_vec++;
      chk("run0_pc", 903, prog_addr, 8'h00);
      chk("run0_icu_rst", 903, 8'(icu_rst), 8'h00);
      chk("run0_instr", 903, 8'(icu_instruction), 8'(LD));
      @(negedge clk);
      #1;
      n_vec++;
      chk("run1_pc", 904, prog_addr, 8'h01);
      chk("run1_instr", 904, 8'(icu_instruction), 8'(AND));
      chk("run1_err", 904, 8'(stack_err), 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
